// File: rtl/tag_fifo.sv
// Free-list FIFO of ROB tags: tags are handed to the dispatcher on allocation
// and returned at retire; reset and flush refill it with every tag 0..DEPTH-1.
module tag_fifo #(
  parameter int TAG_W = 6,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dispatch_en,
  input  logic             dispatch_need_tag,
  output logic [TAG_W-1:0] tag_out,
  output logic             tag_empty,
  output logic [TAG_W:0]   free_count,
  input  logic             retire_spec_valid,
  input  logic             retire_tag_release,
  input  logic [TAG_W-1:0] retire_rd_tag,
  input  logic             flush,
  output logic             overflow_err
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam bit             POW2     = (DEPTH == (1 << TAG_W));

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [TAG_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_W:0]   count_q, count_d;
  logic             err_q, err_d;
  logic             pop_req_s, push_req_s, pop_s, push_s, full_s;

  // Power-of-two depth wraps for free; otherwise wrap explicitly at DEPTH-1.
  function automatic logic [TAG_W-1:0] ptr_inc(input logic [TAG_W-1:0] p);
    if (POW2) begin
      ptr_inc = p + TAG_W'(1);
    end else begin
      ptr_inc = (p == TAG_W'(DEPTH - 1)) ? '0 : p + TAG_W'(1);
    end
  endfunction

  assign tag_empty    = (count_q == '0);
  assign full_s       = (count_q == FULL_CNT);
  assign tag_out      = mem_q[rd_ptr_q];
  assign free_count   = count_q;
  assign overflow_err = err_q;

  assign pop_req_s  = dispatch_en & dispatch_need_tag;
  assign push_req_s = retire_spec_valid & retire_tag_release;
  assign pop_s      = pop_req_s & ~tag_empty;
  assign push_s     = push_req_s & ~full_s;

  // Next-state for pointers, occupancy and the sticky error; flush wins over traffic.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = FULL_CNT;
    end else begin
      if (pop_s) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (push_s) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + (TAG_W+1)'(1);
        2'b01:   count_d = count_q - (TAG_W+1)'(1);
        default: count_d = count_q;
      endcase
      if ((push_req_s & full_s) | (pop_req_s & tag_empty)) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end
  end

  // State registers; reset and flush both reload the identity tag list.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= FULL_CNT;
      err_q    <= 1'b0;
    end else begin
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) mem_q[i] <= TAG_W'(i);
      end else if (push_s) begin
        mem_q[wr_ptr_q] <= retire_rd_tag;
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

endmodule
